// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the multiply/divide unit: md_op encodings, FSM states
// and default latencies used by decode and execute.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  // Ops that occupy the unit for several cycles and must stall dependants
  function automatic logic is_long_op(input md_op_e op);
    logic long_s;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: long_s = 1'b1;
      default:                            long_s = 1'b0;
    endcase
    return long_s;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Execute-stage <-> multiply/divide unit bundle: request operands in,
// HI/LO and hazard status out.
interface mult_div_unit_if;
  import mult_div_unit_pkg::*;

  logic        start;
  md_op_e      md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, md_op, a, b, input busy, md_stall, hi, lo);
  modport slave  (input start, md_op, a, b, output busy, md_stall, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO. The result is
// computed at accept and held back until the fixed latency has elapsed.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  mdu
);

  localparam int unsigned      CNT_W     = $clog2(DIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  md_state_e        state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             busy_r;
  logic [31:0]      hi_r, hi_nxt_s, lo_r, lo_nxt_s;
  logic [31:0]      pend_hi_r, pend_hi_nxt_s, pend_lo_r, pend_lo_nxt_s;
  logic             pend_wr_r, pend_wr_nxt_s;

  logic [63:0] smul_s, umul_s;
  logic [31:0] div_b_s, sdiv_q_s, sdiv_r_s, udiv_q_s, udiv_r_s;
  logic        b_zero_s;

  // Behavioural arithmetic; a zero divisor is replaced so no X/trap reaches state
  always_comb begin
    smul_s   = {{32{mdu.a[31]}}, mdu.a} * {{32{mdu.b[31]}}, mdu.b};
    umul_s   = {32'd0, mdu.a} * {32'd0, mdu.b};
    b_zero_s = (mdu.b == 32'd0);
    div_b_s  = b_zero_s ? 32'd1 : mdu.b;
    sdiv_q_s = $signed(mdu.a) / $signed(div_b_s);
    sdiv_r_s = $signed(mdu.a) % $signed(div_b_s);
    udiv_q_s = mdu.a / div_b_s;
    udiv_r_s = mdu.a % div_b_s;
  end

  // Next-state logic: accept in IDLE, count down in RUN, commit on 1 -> 0
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    hi_nxt_s      = hi_r;
    lo_nxt_s      = lo_r;
    pend_hi_nxt_s = pend_hi_r;
    pend_lo_nxt_s = pend_lo_r;
    pend_wr_nxt_s = pend_wr_r;
    case (state_r)
      ST_IDLE: begin
        if (mdu.start) begin
          case (mdu.md_op)
            MD_MULT: begin
              {pend_hi_nxt_s, pend_lo_nxt_s} = smul_s;
              pend_wr_nxt_s = 1'b1;
              cnt_nxt_s     = MULT_LOAD;
              state_nxt_s   = ST_RUN;
            end
            MD_MULTU: begin
              {pend_hi_nxt_s, pend_lo_nxt_s} = umul_s;
              pend_wr_nxt_s = 1'b1;
              cnt_nxt_s     = MULT_LOAD;
              state_nxt_s   = ST_RUN;
            end
            MD_DIV: begin
              pend_hi_nxt_s = sdiv_r_s;
              pend_lo_nxt_s = sdiv_q_s;
              pend_wr_nxt_s = !b_zero_s;
              cnt_nxt_s     = DIV_LOAD;
              state_nxt_s   = ST_RUN;
            end
            MD_DIVU: begin
              pend_hi_nxt_s = udiv_r_s;
              pend_lo_nxt_s = udiv_q_s;
              pend_wr_nxt_s = !b_zero_s;
              cnt_nxt_s     = DIV_LOAD;
              state_nxt_s   = ST_RUN;
            end
            MD_MTHI: hi_nxt_s = mdu.a;
            MD_MTLO: lo_nxt_s = mdu.a;
            default: state_nxt_s = ST_IDLE;
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == CNT_ONE) begin
          if (pend_wr_r) begin
            hi_nxt_s = pend_hi_r;
            lo_nxt_s = pend_lo_r;
          end else begin
            hi_nxt_s = hi_r;
          end
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = ST_IDLE;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and HI/LO registers; reset aborts any in-flight op
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      busy_r    <= 1'b0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_wr_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      busy_r    <= (state_nxt_s == ST_RUN);
      hi_r      <= hi_nxt_s;
      lo_r      <= lo_nxt_s;
      pend_hi_r <= pend_hi_nxt_s;
      pend_lo_r <= pend_lo_nxt_s;
      pend_wr_r <= pend_wr_nxt_s;
    end
  end

  assign mdu.busy     = busy_r;
  assign mdu.md_stall = busy_r | (mdu.start & is_long_op(mdu.md_op));
  assign mdu.hi       = hi_r;
  assign mdu.lo       = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, results, ignored starts,
// MTHI/MTLO and asynchronous reset during an operation.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mult_div_unit_if mdu ();

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mdu.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one long op, count busy cycles (bounded) and optionally inject a start mid-flight
  task automatic run_op(input string tag, input md_op_e op, input logic [31:0] av,
                        input logic [31:0] bv, input int exp_n, input logic inj,
                        input md_op_e inj_op);
    int n;
    int stall_bad;
    mdu.start = 1'b1; mdu.md_op = op; mdu.a = av; mdu.b = bv;
    #1;
    chk({tag, "_stall_req"}, 32'(mdu.md_stall), 32'd1);
    tick();
    mdu.start = 1'b0; mdu.a = 32'd0; mdu.b = 32'd0;
    n = 0;
    stall_bad = 0;
    while (mdu.busy === 1'b1 && n < 40) begin
      n++;
      if (mdu.md_stall !== 1'b1) stall_bad++;
      if (inj && n == 2) begin
        mdu.start = 1'b1; mdu.md_op = inj_op; mdu.a = 32'h0000_0064; mdu.b = 32'h0000_0003;
      end
      tick();
      mdu.start = 1'b0;
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_n));
    chk({tag, "_stall_busy"}, 32'(stall_bad), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int bsy;
    checks = 0;
    errors = 0;
    reset = 1'b0;
    mdu.start = 1'b0; mdu.md_op = MD_MULT; mdu.a = 32'd0; mdu.b = 32'd0;
    #3;
    chk("rst_busy", 32'(mdu.busy), 32'd0);
    chk("rst_hi", mdu.hi, 32'd0);
    chk("rst_lo", mdu.lo, 32'd0);
    tick();
    reset = 1'b1;
    #1;
    chk("idle_stall", 32'(mdu.md_stall), 32'd0);

    run_op("mult", MD_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 5, 1'b0, MD_MULT);
    chk("mult_hi", mdu.hi, 32'hFFFF_FFFF);
    chk("mult_lo", mdu.lo, 32'hFFFF_FFFE);

    run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 5, 1'b0, MD_MULT);
    chk("multu_hi", mdu.hi, 32'h0000_0001);
    chk("multu_lo", mdu.lo, 32'hFFFF_FFFE);

    run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 10, 1'b0, MD_MULT);
    chk("div_hi", mdu.hi, 32'hFFFF_FFFF);
    chk("div_lo", mdu.lo, 32'hFFFF_FFFD);

    run_op("divu", MD_DIVU, 32'h0000_0007, 32'h0000_0002, 10, 1'b0, MD_MULT);
    chk("divu_hi", mdu.hi, 32'h0000_0001);
    chk("divu_lo", mdu.lo, 32'h0000_0003);

    run_op("mult_big", MD_MULT, 32'h0001_0000, 32'h0001_0000, 5, 1'b0, MD_MULT);
    chk("mult_big_hi", mdu.hi, 32'h0000_0001);
    chk("mult_big_lo", mdu.lo, 32'h0000_0000);

    run_op("div0", MD_DIV, 32'h0000_0005, 32'h0000_0000, 10, 1'b0, MD_MULT);
    chk("div0_hi", mdu.hi, 32'h0000_0001);
    chk("div0_lo", mdu.lo, 32'h0000_0000);

    run_op("ign_div", MD_MULT, 32'h0000_0006, 32'h0000_0007, 5, 1'b1, MD_DIV);
    chk("ign_div_hi", mdu.hi, 32'h0000_0000);
    chk("ign_div_lo", mdu.lo, 32'h0000_002A);

    run_op("ign_mthi", MD_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 5, 1'b1, MD_MTHI);
    chk("ign_mthi_hi", mdu.hi, 32'hFFFF_FFFF);
    chk("ign_mthi_lo", mdu.lo, 32'hFFFF_FFF1);

    mdu.start = 1'b1; mdu.md_op = MD_MTHI; mdu.a = 32'h1234_5678;
    #1;
    chk("mthi_stall", 32'(mdu.md_stall), 32'd0);
    tick();
    mdu.start = 1'b0;
    chk("mthi_hi", mdu.hi, 32'h1234_5678);
    chk("mthi_lo", mdu.lo, 32'hFFFF_FFF1);
    chk("mthi_busy", 32'(mdu.busy), 32'd0);

    mdu.start = 1'b1; mdu.md_op = MD_MTLO; mdu.a = 32'hCAFE_BABE;
    tick();
    mdu.start = 1'b0;
    chk("mtlo_hi", mdu.hi, 32'h1234_5678);
    chk("mtlo_lo", mdu.lo, 32'hCAFE_BABE);

    // DIV aborted by reset during its fourth busy cycle
    mdu.start = 1'b1; mdu.md_op = MD_DIV; mdu.a = 32'h0000_0064; mdu.b = 32'h0000_0007;
    tick();
    mdu.start = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_busy", 32'(mdu.busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("arst_busy", 32'(mdu.busy), 32'd0);
    chk("arst_hi", mdu.hi, 32'd0);
    chk("arst_lo", mdu.lo, 32'd0);
    tick(); tick();
    reset = 1'b1;
    bsy = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (mdu.busy !== 1'b0) bsy++;
    end
    chk("post_rst_busy", 32'(bsy), 32'd0);
    chk("post_rst_hi", mdu.hi, 32'd0);
    chk("post_rst_lo", mdu.lo, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
